// File: rtl/farm_mem_arb.sv
// Single-port memory arbiter: data port (load/store) has priority over the fetch port,
// with a starvation guard that forces a fetch grant after STARVE_MAX back-to-back data wins.
module farm_mem_arb #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state, state_nx;
  logic [2:0] cnt;
  logic [3:0] starve;
  logic       owner_d;
  logic       pick_if, pick_d;
  logic       starved;

  assign starved = (starve == 4'(STARVE_MAX));

  always_comb begin
    pick_if = if_req & (~d_req | starved);
    pick_d  = d_req & ~pick_if;
    // Gated by rst_n so no grant leaks out while the block is held in reset.
    if_gnt  = rst_n & (state == IDLE) & pick_if;
    d_gnt   = rst_n & (state == IDLE) & pick_d;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (if_req | d_req) state_nx = ACCESS;
      ACCESS:  if (cnt == 3'd0)    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      starve    <= '0;
      owner_d   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
    end else begin
      mem_req   <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: if (if_gnt | d_gnt) begin
          mem_req   <= 1'b1;
          owner_d   <= d_gnt;
          cnt       <= 3'(MEM_LAT);
          mem_addr  <= d_gnt ? d_addr : if_addr;
          mem_we    <= d_gnt & d_we;
          mem_be    <= d_gnt ? d_be : '1;
          mem_wdata <= d_gnt ? d_wdata : '0;
          if (if_gnt)
            starve <= '0;
          else if (if_req && !starved)
            starve <= starve + 4'd1;
        end
        ACCESS: begin
          if (cnt == 3'd0) begin
            if (owner_d) begin
              d_rdata  <= mem_we ? '0 : mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
